// File: rtl/samp_pkg.sv
// -----------------------------------------------------------------------------
// samp_pkg
// Shared definitions for the K x K sample-window shift register.
//   PIX_W_DEF  : default pixel width
//   K_MAX      : largest supported kernel edge
//   samp_dir_t : shift direction (new column enters MSB slot or LSB slot)
//   fill_width : width of a counter that must hold the values 0..K
// -----------------------------------------------------------------------------
package samp_pkg;

    localparam int PIX_W_DEF = 4;
    localparam int K_MAX     = 5;

    typedef enum logic {
        DIR_MSB = 1'b0,
        DIR_LSB = 1'b1
    } samp_dir_t;

    // Counter width able to represent 0..k inclusive.
    function automatic int fill_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/samp_win_ctrl.sv
// -----------------------------------------------------------------------------
// samp_win_ctrl
// Handshake and fill tracking for the sample window. Counts the columns
// loaded since the last row boundary or clear, decides when a complete window
// is on the output, and tells the slot array when to shift.
// Ports:
//   clk, n_rst       : clock, synchronous active-low reset
//   clear            : synchronous flush of all fill/window state
//   in_valid/in_ready: column-side handshake
//   in_last          : accepted column closes its row
//   out_valid/ready  : window-side handshake
//   out_last         : current window was completed by a row-closing column
//   shift_en         : one-cycle pulse, slot array shifts in the new column
// -----------------------------------------------------------------------------
module samp_win_ctrl
    import samp_pkg::*;
#(
    parameter int K      = 3,
    parameter int FILL_W = fill_width(K)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic in_valid,
    input  logic in_last,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic out_last,
    output logic shift_en
);

    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(K);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic              row_pend_q, row_pend_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              accept_s;
    logic [FILL_W-1:0] fill_inc_s;

    // A column may enter whenever no window is stuck waiting for the consumer.
    // Holding reset also blocks the producer, so nothing is lost silently.
    assign in_ready  = n_rst && !clear && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign shift_en  = accept_s;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Saturating increment of the fill count.
    always_comb begin
        fill_inc_s = fill_q;
        if (fill_q == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_q + FILL_ONE;
        end
    end

    // Next-state for fill, row boundary flag and the output window status.
    always_comb begin
        fill_d      = fill_q;
        row_pend_d  = row_pend_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (clear) begin
            fill_d      = FILL_ZERO;
            row_pend_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept_s) begin
            // First column after a row end restarts the count; older
            // columns remain in the slots until they are shifted out.
            if (row_pend_q) begin
                fill_d = FILL_ONE;
            end else begin
                fill_d = fill_inc_s;
            end
            row_pend_d  = in_last;
            out_valid_d = (fill_d == FILL_FULL);
            out_last_d  = (fill_d == FILL_FULL) && in_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fill_q      <= FILL_ZERO;
            row_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            row_pend_q  <= row_pend_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: rtl/samp_window_reg.sv
// -----------------------------------------------------------------------------
// samp_window_reg
// Parametrised K x K sample-window shift register feeding the MAC array.
// One K-pixel column is accepted per handshake and shifted into a K-column
// window; each complete window is presented with a valid/ready handshake.
// Ports:
//   clk, n_rst        : clock, synchronous active-low reset
//   clear             : synchronous flush (slots to all ones, fill to 0)
//   dir               : 0 = new column into slot K-1 (MSBs), 1 = into slot 0
//   in_valid/in_ready : column handshake
//   col_in            : incoming column, pixel 0 in the LSBs
//   in_last           : column closes its row
//   out_valid/ready   : window handshake
//   sample_out        : window, slot K-1 in the MSBs
//   out_last          : window was completed by a row-closing column
// -----------------------------------------------------------------------------
module samp_window_reg
    import samp_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int K     = 3,
    parameter int COL_W = K * PIX_W,
    parameter int WIN_W = K * K * PIX_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             dir,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [COL_W-1:0] col_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] sample_out,
    output logic             out_last
);

    if (K < 2 || K > K_MAX) begin : g_bad_k
        $error("samp_window_reg: K must lie in 2..K_MAX");
    end

    samp_dir_t dir_s;
    logic      shift_en_s;

    assign dir_s = samp_dir_t'(dir);

    samp_win_ctrl #(
        .K (K)
    ) u_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .shift_en  (shift_en_s)
    );

    // Slot array: each slot takes either its upper or lower neighbour, with
    // col_in standing in for the neighbour beyond the array edge.
    for (genvar i = 0; i < K; i++) begin : g_slot
        logic [COL_W-1:0] slot_q;
        logic [COL_W-1:0] slot_d;
        logic [COL_W-1:0] from_hi_s;
        logic [COL_W-1:0] from_lo_s;

        if (i == K - 1) begin : g_hi_edge
            assign from_hi_s = col_in;
        end else begin : g_hi_mid
            assign from_hi_s = g_slot[i+1].slot_q;
        end

        if (i == 0) begin : g_lo_edge
            assign from_lo_s = col_in;
        end else begin : g_lo_mid
            assign from_lo_s = g_slot[i-1].slot_q;
        end

        // Select the shift source according to direction, or hold.
        always_comb begin
            slot_d = slot_q;
            if (shift_en_s) begin
                if (dir_s == DIR_LSB) begin
                    slot_d = from_lo_s;
                end else begin
                    slot_d = from_hi_s;
                end
            end else begin
                slot_d = slot_q;
            end
        end

        // Slot register; reset and clear both fill the slot with ones.
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                slot_q <= {COL_W{1'b1}};
            end else if (clear) begin
                slot_q <= {COL_W{1'b1}};
            end else begin
                slot_q <= slot_d;
            end
        end

        assign sample_out[i*COL_W +: COL_W] = slot_q;
    end

endmodule

// File: tb/tb_samp_window_reg.sv
module tb_samp_window_reg;
    import samp_pkg::*;

    localparam int KA = 3;
    localparam int PA = 4;
    localparam int CA = KA * PA;
    localparam int WA = KA * CA;
    localparam int KB = 5;
    localparam int PB = 8;
    localparam int CB = KB * PB;
    localparam int WB = KB * CB;

    logic clk;

    logic          a_n_rst, a_clear, a_dir, a_in_valid, a_in_ready, a_in_last;
    logic          a_out_valid, a_out_ready, a_out_last;
    logic [CA-1:0] a_col;
    logic [WA-1:0] a_sample;

    logic          b_n_rst, b_clear, b_dir, b_in_valid, b_in_ready, b_in_last;
    logic          b_out_valid, b_out_ready, b_out_last;
    logic [CB-1:0] b_col;
    logic [WB-1:0] b_sample;

    samp_window_reg #(.PIX_W(PA), .K(KA)) dut_a (
        .clk(clk), .n_rst(a_n_rst), .clear(a_clear), .dir(a_dir),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .col_in(a_col),
        .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sample_out(a_sample), .out_last(a_out_last)
    );

    samp_window_reg #(.PIX_W(PB), .K(KB)) dut_b (
        .clk(clk), .n_rst(b_n_rst), .clear(b_clear), .dir(b_dir),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .col_in(b_col),
        .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sample_out(b_sample), .out_last(b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (window as a list of columns) --------
    logic [CA-1:0] m_win [KA];
    int            m_fill = 0;
    bit            m_pend = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_last = 1'b0;

    function automatic bit m_ready(input bit rst, input bit clr, input bit ordy);
        return rst && !clr && (!m_valid || ordy);
    endfunction

    function automatic logic [WA-1:0] m_sample();
        logic [WA-1:0] r;
        for (int k = 0; k < KA; k++) r[k*CA +: CA] = m_win[k];
        return r;
    endfunction

    task automatic m_step(input bit v, input logic [CA-1:0] c, input bit l,
                          input bit ordy, input bit d, input bit clr, input bit rst);
        bit acc;
        acc = v && m_ready(rst, clr, ordy);
        if (!rst || clr) begin
            for (int k = 0; k < KA; k++) m_win[k] = '1;
            m_fill = 0; m_pend = 1'b0; m_valid = 1'b0; m_last = 1'b0;
        end else if (acc) begin
            if (!d) begin
                for (int k = 0; k < KA - 1; k++) m_win[k] = m_win[k+1];
                m_win[KA-1] = c;
            end else begin
                for (int k = KA - 1; k > 0; k--) m_win[k] = m_win[k-1];
                m_win[0] = c;
            end
            m_fill  = m_pend ? 1 : ((m_fill < KA) ? m_fill + 1 : KA);
            m_pend  = l;
            m_valid = (m_fill == KA);
            m_last  = m_valid && l;
        end else if (ordy) begin
            m_valid = 1'b0;
            m_last  = 1'b0;
        end
    endtask

    // Apply one cycle of inputs to DUT A, check against the model.
    task automatic cyc(input bit v, input logic [CA-1:0] c, input bit l,
                       input bit ordy, input bit d, input bit clr, input bit rst);
        a_in_valid = v; a_col = c; a_in_last = l; a_out_ready = ordy;
        a_dir = d; a_clear = clr; a_n_rst = rst;
        #1;
        chk("in_ready", {255'd0, a_in_ready}, {255'd0, m_ready(rst, clr, ordy)});
        @(posedge clk);
        m_step(v, c, l, ordy, d, clr, rst);
        #1;
        chk("out_valid", {255'd0, a_out_valid}, {255'd0, m_valid});
        chk("out_last", {255'd0, a_out_last}, {255'd0, m_last});
        chk("sample_out", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, m_sample()});
    endtask

    task automatic exp_vl(input string name, input bit ev, input bit el);
        chk({name, " valid"}, {255'd0, a_out_valid}, {255'd0, ev});
        chk({name, " last"}, {255'd0, a_out_last}, {255'd0, el});
    endtask

    typedef struct {
        bit            v;
        logic [CA-1:0] c;
        bit            l;
        bit            ordy;
        bit            d;
        bit            clr;
        bit            rst;
        bit            ev;
        bit            el;
        logic [WA-1:0] es;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit dir_r;
        logic [CB-1:0] bc [KB];
        logic [WB-1:0] bexp;

        for (int k = 0; k < KA; k++) m_win[k] = '1;
        a_n_rst = 1'b0; a_clear = 1'b0; a_dir = 1'b0; a_in_valid = 1'b0;
        a_in_last = 1'b0; a_out_ready = 1'b1; a_col = '0;
        b_n_rst = 1'b0; b_clear = 1'b0; b_dir = 1'b0; b_in_valid = 1'b0;
        b_in_last = 1'b0; b_out_ready = 1'b1; b_col = '0;

        //          v     col      l     ordy  d     clr   rst   ev    el    sample
        tbl[0]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'hFFFFFFFFF};
        tbl[1]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'hFFFFFFFFF};
        tbl[2]  = '{1'b1, 12'h111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h111FFFFFF};
        tbl[3]  = '{1'b1, 12'h222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h222111FFF};
        tbl[4]  = '{1'b1, 12'h333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h333222111};
        tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h333222111};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 36'hFFFFFFFFF};
        tbl[7]  = '{1'b1, 12'h111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 36'hFFFFFF111};
        tbl[8]  = '{1'b1, 12'h222, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 36'hFFF111222};
        tbl[9]  = '{1'b1, 12'h333, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 36'h111222333};
        tbl[10] = '{1'b1, 12'h444, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 36'h222333444};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 36'h222333444};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].ordy, tbl[i].d, tbl[i].clr, tbl[i].rst);
            exp_vl($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].el);
            chk($sformatf("tbl%0d sample", i), {{(256-WA){1'b0}}, a_sample},
                {{(256-WA){1'b0}}, tbl[i].es});
        end

        // Row boundary: 4 columns (last on 4th), then 3 columns of new row.
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 12'hA01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row c1", 1'b0, 1'b0);
        cyc(1'b1, 12'hA02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row c2", 1'b0, 1'b0);
        cyc(1'b1, 12'hA03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row c3", 1'b1, 1'b0);
        cyc(1'b1, 12'hA04, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row c4", 1'b1, 1'b1);
        chk("row w4", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'hA04A03A02});
        cyc(1'b1, 12'hB01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row n1", 1'b0, 1'b0);
        cyc(1'b1, 12'hB02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row n2", 1'b0, 1'b0);
        cyc(1'b1, 12'hB03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("row n3", 1'b1, 1'b0);

        // Short row: 2 columns then a fresh row needing 3 accepts.
        cyc(1'b1, 12'hC01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 12'hC01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("short c1", 1'b0, 1'b0);
        cyc(1'b1, 12'hC02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("short c2", 1'b0, 1'b0);
        cyc(1'b1, 12'hD01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("short n1", 1'b0, 1'b0);
        cyc(1'b1, 12'hD02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("short n2", 1'b0, 1'b0);
        cyc(1'b1, 12'hD03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); exp_vl("short n3", 1'b1, 1'b0);

        // Backpressure: window pending, consumer stalled for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 12'hE00 + 12'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("bp in_ready", {255'd0, a_in_ready}, 256'd0);
            chk("bp sample", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'hD03D02D01});
        end
        cyc(1'b1, 12'hE55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp release", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'hE55D03D02});
        exp_vl("bp release", 1'b1, 1'b0);

        // Reset with a window pending.
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 12'h777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_vl("rst pend", 1'b0, 1'b0);
        chk("rst sample", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'hFFFFFFFFF});
        chk("rst in_ready", {255'd0, a_in_ready}, 256'd0);

        // Clear mid-fill with a column presented alongside it.
        cyc(1'b1, 12'h501, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 12'h502, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_vl("clr", 1'b0, 1'b0);
        chk("clr sample", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'hFFFFFFFFF});
        cyc(1'b1, 12'h555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr next", {{(256-WA){1'b0}}, a_sample}, {{(256-WA){1'b0}}, 36'h555FFFFFF});
        cyc(1'b1, 12'h556, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("clr f2", 1'b0, 1'b0);
        cyc(1'b1, 12'h557, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); exp_vl("clr f3", 1'b1, 1'b0);

        // Randomised traffic against the model.
        dir_r = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bit v, l, ordy, clr, rst;
            v    = ($urandom_range(0, 3) != 0);
            l    = ($urandom_range(0, 4) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            rst  = ($urandom_range(0, 79) != 0);
            if ((m_pend || m_fill == 0) && $urandom_range(0, 2) == 0) dir_r = ~dir_r;
            cyc(v, CA'($urandom), l, ordy, dir_r, clr, rst);
        end

        // K=5, PIX_W=8 instance.
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_clear = 1'b0; a_n_rst = 1'b1;
        @(posedge clk); #1;
        chk("b reset sample", {56'd0, b_sample}, {56'd0, {WB{1'b1}}});
        chk("b reset valid", {255'd0, b_out_valid}, 256'd0);
        b_n_rst = 1'b1;
        for (int i = 0; i < KB; i++) begin
            bc[i] = 40'h0101010101 * 40'(i + 1);
            b_in_valid = 1'b1; b_col = bc[i];
            @(posedge clk); #1;
            chk($sformatf("b valid after %0d", i + 1), {255'd0, b_out_valid},
                {255'd0, (i == KB - 1)});
        end
        b_in_valid = 1'b0;
        bexp = {bc[4], bc[3], bc[2], bc[1], bc[0]};
        chk("b window", {56'd0, b_sample}, {56'd0, bexp});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
